// File: rtl/mcycle_unit_pkg.sv
// mcycle_unit_pkg: shared opcode and FSM state encodings for the multi-cycle MUL/DIV unit.
package mcycle_unit_pkg;

    localparam logic MCYCLE_MUL = 1'b0;
    localparam logic MCYCLE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/mcycle_unit_if.sv
// mcycle_unit_if: request/result bundle between the control/execute stage and mcycle_unit.
interface mcycle_unit_if #(parameter int WIDTH = 32);

    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );

endinterface

// File: rtl/mcycle_unit_negate.sv
// mcycle_negate: conditional two's-complement of a WIDTH-bit word.
// Only compiled when MCYCLE_SIGNED_EN is defined; the unsigned build has no use for it.
`ifdef MCYCLE_SIGNED_EN
module mcycle_negate #(parameter int WIDTH = 32) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule
`endif

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / restoring divide, WIDTH cycles per operation.
// Optional MCYCLE_SIGNED_EN: two's-complement operands (magnitudes at accept, sign fix-up on the DONE write).
module mcycle_unit #(parameter int WIDTH = 32) (
    input  logic         CLK,
    input  logic         RESETn,
    mcycle_unit_if.slave bus
);
    import mcycle_unit_pkg::*;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state_r, state_nx_s;
    logic [CW-1:0]      count_r, count_nx_s;
    // MUL: {partial product high, multiplier}; DIV: {remainder, quotient/dividend}
    logic [2*WIDTH-1:0] acc_r, acc_nx_s, step_acc_s;
    // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0]   opnd_r, opnd_nx_s;
    logic [WIDTH-1:0]   res1_r, res1_nx_s, res2_r, res2_nx_s;
    logic               op_r, op_nx_s, done_r, done_nx_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s, fix_lo_s, fix_hi_s;
    logic               accept_s;

    logic [WIDTH:0]     mul_sum_s, div_rem_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic               div_ge_s;

    assign accept_s = (state_r == IDLE) && bus.Start;

    // One iteration of either algorithm; the add keeps its carry in bit WIDTH
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign div_rem_s  = acc_r[2*WIDTH-1:WIDTH-1];
    assign div_ge_s   = (div_rem_s >= {1'b0, opnd_r});
    assign div_diff_s = div_rem_s[WIDTH-1:0] - opnd_r;
    assign step_acc_s = (op_r == MCYCLE_DIV)
                      ? {(div_ge_s ? div_diff_s : div_rem_s[WIDTH-1:0]), acc_r[WIDTH-2:0], div_ge_s}
                      : {mul_sum_s, acc_r[WIDTH-1:1]};

`ifdef MCYCLE_SIGNED_EN
    logic               sign1_r, sign2_r;
    logic [WIDTH-1:0]   dividend_r, quot_fix_s, rem_fix_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic               div_zero_s;

    mcycle_negate #(.WIDTH(WIDTH))   u_abs1 (.neg(bus.Operand1[WIDTH-1]), .din(bus.Operand1), .dout(mag1_s));
    mcycle_negate #(.WIDTH(WIDTH))   u_abs2 (.neg(bus.Operand2[WIDTH-1]), .din(bus.Operand2), .dout(mag2_s));
    mcycle_negate #(.WIDTH(2*WIDTH)) u_prod (.neg(sign1_r ^ sign2_r), .din(step_acc_s), .dout(prod_fix_s));
    mcycle_negate #(.WIDTH(WIDTH))   u_quot (.neg(sign1_r ^ sign2_r), .din(step_acc_s[WIDTH-1:0]),
                                             .dout(quot_fix_s));
    mcycle_negate #(.WIDTH(WIDTH))   u_rem  (.neg(sign1_r), .din(step_acc_s[2*WIDTH-1:WIDTH]),
                                             .dout(rem_fix_s));

    // Divide by zero must report the raw dividend, which the sign fix-up would otherwise distort
    assign div_zero_s = (opnd_r == {WIDTH{1'b0}});
    assign fix_lo_s   = (op_r == MCYCLE_DIV) ? (div_zero_s ? {WIDTH{1'b1}} : quot_fix_s)
                                             : prod_fix_s[WIDTH-1:0];
    assign fix_hi_s   = (op_r == MCYCLE_DIV) ? (div_zero_s ? dividend_r : rem_fix_s)
                                             : prod_fix_s[2*WIDTH-1:WIDTH];

    // Capture operand signs and the raw dividend on accept for the DONE fix-up
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            dividend_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            sign1_r    <= bus.Operand1[WIDTH-1];
            sign2_r    <= bus.Operand2[WIDTH-1];
            dividend_r <= bus.Operand1;
        end
    end
`else
    assign mag1_s   = bus.Operand1;
    assign mag2_s   = bus.Operand2;
    assign fix_lo_s = step_acc_s[WIDTH-1:0];
    assign fix_hi_s = step_acc_s[2*WIDTH-1:WIDTH];
`endif

    // Next-state and datapath updates; results are written on the edge that enters DONE
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        acc_nx_s   = acc_r;
        opnd_nx_s  = opnd_r;
        op_nx_s    = op_r;
        res1_nx_s  = res1_r;
        res2_nx_s  = res2_r;
        done_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    // Multiply is commutative, so both ops load Operand1 into the low half
                    state_nx_s = COMPUTE;
                    count_nx_s = {CW{1'b0}};
                    op_nx_s    = bus.MCycleOp;
                    acc_nx_s   = {{WIDTH{1'b0}}, mag1_s};
                    opnd_nx_s  = mag2_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COMPUTE: begin
                acc_nx_s   = step_acc_s;
                count_nx_s = count_r + CW'(1);
                if (count_r == LAST) begin
                    state_nx_s = DONE;
                    done_nx_s  = 1'b1;
                    res1_nx_s  = fix_lo_s;
                    res2_nx_s  = fix_hi_s;
                end else begin
                    state_nx_s = COMPUTE;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            op_r    <= 1'b0;
            res1_r  <= {WIDTH{1'b0}};
            res2_r  <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            acc_r   <= acc_nx_s;
            opnd_r  <= opnd_nx_s;
            op_r    <= op_nx_s;
            res1_r  <= res1_nx_s;
            res2_r  <= res2_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Busy must rise in the request cycle itself to stall the issuing instruction
    assign bus.Busy    = RESETn & (accept_s | (state_r == COMPUTE));
    assign bus.Result1 = res1_r;
    assign bus.Result2 = res2_r;
    assign bus.Done    = done_r;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: table vectors, hand-written corner sequences and random ops against a
// plain-arithmetic reference model. Expectations follow MCYCLE_SIGNED_EN when defined.
module tb_mcycle_unit;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mcycle_unit_if #(.WIDTH(W)) bus();
    mcycle_unit #(.WIDTH(W)) dut (.CLK(clk), .RESETn(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          scramble;
        int          pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] e1, output logic [31:0] e2);
`ifdef MCYCLE_SIGNED_EN
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1'b0) begin
            p  = sa * sb;
            e1 = p[31:0];
            e2 = p[63:32];
        end else if (b == 32'd0) begin
            e1 = 32'hFFFF_FFFF;
            e2 = a;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            e1 = q[31:0];
            e2 = r[31:0];
        end
`else
        logic [63:0] p;
        if (op == 1'b0) begin
            p  = {32'd0, a} * {32'd0, b};
            e1 = p[31:0];
            e2 = p[63:32];
        end else if (b == 32'd0) begin
            e1 = 32'hFFFF_FFFF;
            e2 = a;
        end else begin
            e1 = a / b;
            e2 = a % b;
        end
`endif
    endfunction

    // Issue one op, optionally disturb inputs after accept, and track Busy/Done shape.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input int pulse_n,
                         output logic [31:0] r1, output logic [31:0] r2,
                         output int lat, output bit shape_ok);
        shape_ok = 1'b1;
        lat = 0;
        r1 = 32'd0;
        r2 = 32'd0;
        @(negedge clk);
        bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
        #1;
        if (bus.Busy !== 1'b1) shape_ok = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                lat = n;
                r1 = bus.Result1;
                r2 = bus.Result2;
                if (bus.Busy !== 1'b0) shape_ok = 1'b0;
                break;
            end
            if (bus.Busy !== 1'b1) shape_ok = 1'b0;
            if (n == 1) begin
                bus.Start = 1'b0;
                if (scramble) begin
                    bus.Operand1 = $urandom; bus.Operand2 = $urandom; bus.MCycleOp = ~op;
                end
            end
            if (n == pulse_n) begin
                bus.Start = 1'b1; bus.Operand1 = $urandom; bus.Operand2 = $urandom;
            end
            if (pulse_n > 0 && n == pulse_n + 1) bus.Start = 1'b0;
        end
        bus.Start = 1'b0;
        @(negedge clk);
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) shape_ok = 1'b0;
    endtask

    task automatic run_check(input string name, input logic op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                             input bit scramble, input int pulse_n);
        logic [31:0] r1, r2;
        int          lat;
        bit          shape_ok;
        do_op(op, a, b, scramble, pulse_n, r1, r2, lat, shape_ok);
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_result1"}, {32'd0, r1}, {32'd0, e1});
        check({name, "_result2"}, {32'd0, r2}, {32'd0, e2});
        check({name, "_busy_done_shape"}, {63'd0, shape_ok}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e1, e2, a, b;
        logic        op;
        int          first, second;
        logic        busy34, done34, saw_done;

`ifdef MCYCLE_SIGNED_EN
        vecs.push_back('{1'b0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 0});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0});
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 0});
        vecs.push_back('{1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 10});
        vecs.push_back('{1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0});
        vecs.push_back('{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000, 1'b0, 0});
`else
        vecs.push_back('{1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 0});
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 0});
        vecs.push_back('{1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 10});
        vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0, 0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0});
        vecs.push_back('{1'b1, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 0});
`endif

        bus.Start = 1'b0; bus.MCycleOp = 1'b0; bus.Operand1 = 32'd0; bus.Operand2 = 32'd0;

        // Reset state, with Start asserted to show Busy is held low during reset
        @(negedge clk);
        bus.Start = 1'b1;
        #1;
        check("reset_busy", {63'd0, bus.Busy}, 64'd0);
        check("reset_done", {63'd0, bus.Done}, 64'd0);
        check("reset_result1", {32'd0, bus.Result1}, 64'd0);
        check("reset_result2", {32'd0, bus.Result2}, 64'd0);
        bus.Start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].e1, vecs[i].e2, vecs[i].scramble, vecs[i].pulse);
        end

        // Start held high: back-to-back MUL 3 x 5 with exactly one idle cycle between them
        first = 0; second = 0; busy34 = 1'b0; done34 = 1'b1;
        @(negedge clk);
        bus.Start = 1'b1; bus.MCycleOp = 1'b0; bus.Operand1 = 32'd3; bus.Operand2 = 32'd5;
        for (int n = 0; n <= 80 && second == 0; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 34) begin busy34 = bus.Busy; done34 = bus.Done; end
            if (bus.Done === 1'b1) begin
                if (first == 0) first = n;
                else second = n;
            end
        end
        bus.Start = 1'b0;
        check("b2b_first_done", 64'(first), 64'(LAT));
        check("b2b_second_done", 64'(second), 64'(2 * LAT + 1));
        check("b2b_idle_busy", {63'd0, busy34}, 64'd1);
        check("b2b_idle_done", {63'd0, done34}, 64'd0);
        check("b2b_result1", {32'd0, bus.Result1}, 64'd15);

        // Reset at cycle 10 of a divide aborts it with no Done
        @(negedge clk);
        bus.Start = 1'b1; bus.MCycleOp = 1'b1; bus.Operand1 = 32'd1000; bus.Operand2 = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        bus.Start = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.Busy}, 64'd0);
        check("abort_done", {63'd0, bus.Done}, 64'd0);
        check("abort_result1", {32'd0, bus.Result1}, 64'd0);
        check("abort_result2", {32'd0, bus.Result2}, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) saw_done = 1'b1;
        end
        bus.Start = 1'b0;
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        run_check("after_abort_mul", 1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 0);

        // Random ops against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(op, a, b, e1, e2);
            run_check($sformatf("rand%0d", i), op, a, b, e1, e2, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
